// File: rtl/jam_pkg.sv
// Shared types and widths for the job-assignment cost ROM arbiter.
package jam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int IDX_W  = 3;
    localparam int COST_W = 7;
    localparam int CNT_W  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping modulo NREQ.
module rr_pick
    import jam_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [PW-1:0]   winner,
    output logic            found
);

    int idx;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (req[idx]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cost_rom_arb.sv
// Burst arbiter giving NREQ permutation evaluators turns at one cost ROM,
// with early end, idle timeout and a one-cycle drain between grants.
module cost_rom_arb
    import jam_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int BURST    = 8,
    parameter int IDLE_MAX = 15
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_last,
    input  logic [IDX_W*NREQ-1:0]   req_W,
    input  logic [IDX_W*NREQ-1:0]   req_J,
    output logic [NREQ-1:0]         gnt,
    output logic [IDX_W-1:0]        W,
    output logic [IDX_W-1:0]        J,
    input  logic [COST_W-1:0]       Cost,
    output logic [COST_W-1:0]       rdata,
    output logic [NREQ-1:0]         rvalid
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_e              state_q, state_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]    w_q, w_d;
    logic [IDX_W-1:0]    j_q, j_d;
    logic                issue_q, issue_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [COST_W-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0]     rvalid_q, rvalid_d;

    logic [PW-1:0]       win;
    logic                win_vld;
    logic                own_req;
    logic                own_last;
    logic [IDX_W-1:0]    own_w;
    logic [IDX_W-1:0]    own_j;
    logic                burst_end;
    logic                idle_end;
    logic [PW-1:0]       next_ptr;

    rr_pick #(
        .NREQ   (NREQ),
        .PW     (PW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (win),
        .found  (win_vld)
    );

    assign own_req   = req[owner_q];
    assign own_last  = req_last[owner_q];
    assign own_w     = req_W[int'(owner_q)*IDX_W +: IDX_W];
    assign own_j     = req_J[int'(owner_q)*IDX_W +: IDX_W];
    assign burst_end = own_last || (cnt_q == CNT_W'(BURST - 1));
    assign idle_end  = (idle_cnt_q == CNT_W'(IDLE_MAX));
    assign next_ptr  = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        w_d        = w_q;
        j_d        = j_q;
        issue_d    = 1'b0;
        cnt_d      = cnt_q;
        idle_cnt_d = idle_cnt_q;
        rdata_d    = rdata_q;
        rvalid_d   = '0;

        // A read registered last edge has its ROM word on Cost now.
        if (issue_q) begin
            rdata_d  = Cost;
            rvalid_d = ONE << owner_q;
        end

        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d    = win;
                    gnt_d      = ONE << win;
                    cnt_d      = '0;
                    idle_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (own_req) begin
                    w_d        = own_w;
                    j_d        = own_j;
                    issue_d    = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    idle_cnt_d = '0;
                    if (burst_end) begin
                        gnt_d   = '0;
                        state_d = DRAIN;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    if (idle_end) begin
                        gnt_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                rr_ptr_d = next_ptr;
                state_d  = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            w_q        <= '0;
            j_q        <= '0;
            issue_q    <= 1'b0;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            w_q        <= w_d;
            j_q        <= j_d;
            issue_q    <= issue_d;
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign gnt    = gnt_q;
    assign W      = w_q;
    assign J      = j_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule
